// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// The bridge uses modport master; the command source plus APB slave side use modport slave.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [DATA_W-1:0] CMD_WDATA;
    logic              RSP_VALID;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PRDATA, PREADY,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PRDATA, PREADY,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS, one RSP_VALID pulse per command.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  SYSCLK,
    input  logic                  RST,
    apb_master_bridge_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] tmo_cnt;
    logic       rsp_err_q;

    assign bus.RSP_ERR = rsp_err_q;
`else
    // TIMEOUT_CYC only matters with the timeout feature; keep the range check visible.
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_illegal_timeout_cyc
    end

    assign bus.RSP_ERR = 1'b0;
`endif

    assign bus.CMD_READY = (state == IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rsp_rdata_q;

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CMD_VALID) begin
                        pwrite_q <= bus.CMD_WRITE;
                        paddr_q  <= bus.CMD_ADDR;
                        pwdata_q <= bus.CMD_WDATA;
                        psel_q   <= 1'b1;
                        state    <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a coincident timeout expiry.
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; timeout checks follow APB_MASTER_TIMEOUT_EN.
module tb_apb_master_bridge;

    logic SYSCLK = 1'b0;
    logic RST    = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    apb_master_bridge_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .TIMEOUT_CYC(4)
    ) dut (
        .SYSCLK(SYSCLK),
        .RST   (RST),
        .bus   (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    // Runs an already-accepted transfer from SETUP until RSP_VALID; PREADY rises once
    // PENABLE has been seen `ready_at` times (0 = never).
    task automatic run_access(input int ready_at, input logic [31:0] rdata,
                              output int pen, output logic got_rsp);
        pen     = 0;
        got_rsp = 1'b0;
        for (int i = 0; i < 40 && !got_rsp; i++) begin
            if (bus.PENABLE) pen++;
            bus.PREADY = (ready_at != 0) && (pen >= ready_at);
            bus.PRDATA = bus.PREADY ? rdata : 32'hDEAD_BEEF;
            step();
            if (bus.RSP_VALID) got_rsp = 1'b1;
        end
    endtask

    int   pen;
    logic got_rsp;

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b1;

        #1 RST = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
        check("rst_psel",      32'(bus.PSEL), 32'd0);
        check("rst_penable",   32'(bus.PENABLE), 32'd0);
        check("rst_paddr",     32'(bus.PADDR), 32'd0);
        check("rst_pwdata",    bus.PWDATA, 32'd0);
        check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("rst_rsp_err",   32'(bus.RSP_ERR), 32'd0);

        // Write, PREADY=1, accepted at first edge after reset release
        #10 RST = 1'b0;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_ADDR  = 5'h01;
        bus.CMD_WDATA = 32'h0000_00FF;
        step();
        check("wr_setup_psel",    32'(bus.PSEL), 32'd1);
        check("wr_setup_penable", 32'(bus.PENABLE), 32'd0);
        check("wr_setup_ready",   32'(bus.CMD_READY), 32'd0);
        check("wr_setup_paddr",   32'(bus.PADDR), 32'h01);
        check("wr_setup_pwrite",  32'(bus.PWRITE), 32'd1);
        check("wr_setup_pwdata",  bus.PWDATA, 32'h0000_00FF);
        bus.CMD_VALID = 1'b0;
        step();
        check("wr_access_penable", 32'(bus.PENABLE), 32'd1);
        check("wr_access_psel",    32'(bus.PSEL), 32'd1);
        check("wr_access_rsp",     32'(bus.RSP_VALID), 32'd0);
        check("wr_access_pwdata",  bus.PWDATA, 32'h0000_00FF);
        step();
        check("wr_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
        check("wr_rsp_err",   32'(bus.RSP_ERR), 32'd0);
        check("wr_rsp_rdata", bus.RSP_RDATA, 32'd0);
        check("wr_rsp_psel",  32'(bus.PSEL), 32'd0);
        check("wr_rsp_ready", 32'(bus.CMD_READY), 32'd1);
        step();
        check("wr_rsp_pulse", 32'(bus.RSP_VALID), 32'd0);
        check("wr_idle_pwdata_hold", bus.PWDATA, 32'h0000_00FF);

        // Read with three wait states (also coincides with timeout expiry when enabled)
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 5'h00;
        step();
        bus.CMD_VALID = 1'b0;
        run_access(4, 32'h0000_000E, pen, got_rsp);
        check("rd_got_rsp",  32'(got_rsp), 32'd1);
        check("rd_penable_cycles", 32'(pen), 32'd4);
        check("rd_rdata",    bus.RSP_RDATA, 32'h0000_000E);
        check("rd_err",      32'(bus.RSP_ERR), 32'd0);
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h5555_5555;
        step();
        check("rd_rdata_hold", bus.RSP_RDATA, 32'h0000_000E);
        check("rd_valid_drop", 32'(bus.RSP_VALID), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        bus.CMD_VALID = 1'b1;
        bus.CMD_ADDR  = 5'h02;
        step();
        bus.CMD_VALID = 1'b0;
        run_access(0, 32'h0, pen, got_rsp);
        check("tmo_got_rsp",  32'(got_rsp), 32'd1);
        check("tmo_access_cycles", 32'(pen), 32'd4);
        check("tmo_err",      32'(bus.RSP_ERR), 32'd1);
        check("tmo_rdata",    bus.RSP_RDATA, 32'd0);
        check("tmo_cmd_ready", 32'(bus.CMD_READY), 32'd1);
        check("tmo_psel",     32'(bus.PSEL), 32'd0);
`else
        bus.CMD_VALID = 1'b1;
        bus.CMD_ADDR  = 5'h02;
        step();
        bus.CMD_VALID = 1'b0;
        run_access(25, 32'h0000_0077, pen, got_rsp);
        check("long_wait_got_rsp", 32'(got_rsp), 32'd1);
        check("long_wait_cycles",  32'(pen), 32'd25);
        check("long_wait_err",     32'(bus.RSP_ERR), 32'd0);
        check("long_wait_rdata",   bus.RSP_RDATA, 32'h0000_0077);
`endif
        bus.PREADY = 1'b1;
        step();

        // Back-to-back: write then read with CMD_VALID held high
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_ADDR  = 5'h03;
        bus.CMD_WDATA = 32'h0000_1111;
        step();
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 5'h07;
        bus.CMD_WDATA = 32'h0000_2222;
        bus.PRDATA    = 32'h0000_1234;
        step();
        check("b2b_a_paddr",  32'(bus.PADDR), 32'h03);
        check("b2b_a_pwrite", 32'(bus.PWRITE), 32'd1);
        check("b2b_a_pwdata", bus.PWDATA, 32'h0000_1111);
        step();
        check("b2b_a_rsp",   32'(bus.RSP_VALID), 32'd1);
        check("b2b_a_err",   32'(bus.RSP_ERR), 32'd0);
        check("b2b_gap_psel", 32'(bus.PSEL), 32'd0);
        check("b2b_gap_ready", 32'(bus.CMD_READY), 32'd1);
        step();
        bus.CMD_VALID = 1'b0;
        check("b2b_b_psel",   32'(bus.PSEL), 32'd1);
        check("b2b_b_paddr",  32'(bus.PADDR), 32'h07);
        check("b2b_b_pwrite", 32'(bus.PWRITE), 32'd0);
        check("b2b_b_rsp_drop", 32'(bus.RSP_VALID), 32'd0);
        step();
        step();
        check("b2b_b_rsp",   32'(bus.RSP_VALID), 32'd1);
        check("b2b_b_rdata", bus.RSP_RDATA, 32'h0000_1234);

        // Command fields change during SETUP/ACCESS must not leak onto the bus
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_ADDR  = 5'h0A;
        bus.CMD_WDATA = 32'hCAFE_0001;
        step();
        bus.CMD_VALID = 1'b0;
        bus.CMD_ADDR  = 5'h1F;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_WDATA = 32'h0BAD_0BAD;
        bus.PREADY    = 1'b0;
        step();
        step();
        check("hold_paddr_access",  32'(bus.PADDR), 32'h0A);
        check("hold_pwrite_access", 32'(bus.PWRITE), 32'd1);
        check("hold_pwdata_access", bus.PWDATA, 32'hCAFE_0001);
        bus.PREADY = 1'b1;
        step();
        check("hold_rsp",        32'(bus.RSP_VALID), 32'd1);
        check("hold_paddr_idle", 32'(bus.PADDR), 32'h0A);
        check("hold_wr_rdata",   bus.RSP_RDATA, 32'd0);
        step();

        // Reset asserted mid-ACCESS aborts without a response
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 5'h04;
        bus.PREADY    = 1'b0;
        step();
        bus.CMD_VALID = 1'b0;
        step();
        check("abort_penable_pre", 32'(bus.PENABLE), 32'd1);
        RST = 1'b1;
        #1;
        check("abort_psel",    32'(bus.PSEL), 32'd0);
        check("abort_penable", 32'(bus.PENABLE), 32'd0);
        check("abort_ready",   32'(bus.CMD_READY), 32'd1);
        check("abort_rdata",   bus.RSP_RDATA, 32'd0);
        #2 RST = 1'b0;
        bus.PREADY = 1'b1;
        got_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.RSP_VALID) got_rsp = 1'b1;
        end
        check("abort_no_rsp",   32'(got_rsp), 32'd0);
        check("abort_idle_ready", 32'(bus.CMD_READY), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
